i2c_master_bus: RTL

- Byte-level I2C master engine with a local-bus register interface.
- Parametrised successor to the bare `i2c_master_ip`.
- Adds a programmable SCL prescaler, START/STOP/repeated-START command sequencing, read/write with ACK control, and status reporting.
- Sits on the SoC local bus beside the GPIO and UART peripherals. I2C pins are open-drain, driven via output enables.

---
 rtl/i2c_master_bus.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_bus.sv
// i2c_master_bus: byte-level I2C master engine behind a local-bus register interface.
//
// Register map (addr[3:2]):
//   0 CMD      (W)  bit0 START, bit1 STOP, bit2 WRITE, bit3 READ, bit4 NACK; reads as 0
//   1 DATA     (RW) write loads TXDATA[7:0], read returns RXDATA[7:0]
//   2 STATUS   (RW) bit0 BUSY, bit1 RX_NACK, bit2 CMD_ERR (sticky, write 1 to clear)
//   3 PRESCALE (RW) quarter period minus one; 0 is stored as 1, writes ignored while BUSY
//
// Ports:
//   clk, reset_n               system clock, asynchronous active-low reset
//   waddr/wdata/wen/wstrb      write channel, wready pulses one cycle after wen
//   raddr/ren                  read channel, rdata/rvalid registered one cycle after ren
//   scl_oe/sda_oe              open-drain enables (1 = pull line low)
//   scl_i/sda_i                pin sense
//
// Optional feature: define I2C_CLK_STRETCH_EN to let a slave stretch SCL. Without it scl_i
// is ignored and bus timing is fixed.
module i2c_master_bus #(
    parameter int unsigned PRESCALE_W       = 16,
    parameter int unsigned DEFAULT_PRESCALE = 124
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic        wen,
    input  logic [3:0]  wstrb,
    output logic        wready,
    input  logic [31:0] raddr,
    input  logic        ren,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        scl_oe,
    input  logic        scl_i,
    output logic        sda_oe,
    input  logic        sda_i
);

    typedef enum logic [1:0] {StIdle, StStart, StBit, StStop} state_e;

    state_e                state_q;
    logic [PRESCALE_W-1:0] prescale_q, prescale_wr, cnt_q;
    logic [1:0]            qtr_q;
    logic [3:0]            bit_q;
    logic [7:0]            txdata_q, rxdata_q;
    logic                  busy_q, rx_nack_q, cmd_err_q;
    logic                  cmd_stop_q, cmd_write_q, cmd_read_q, cmd_nack_q;
    logic                  scl_oe_q, sda_oe_q, wready_q, rvalid_q;
    logic [31:0]           rdata_q, rdata_mux;
    logic                  stall, qend;
    logic                  unused_inputs;

    // SDA drive for bit slot idx: data bits carry ~TXDATA when writing, the ACK slot
    // carries ~NACK when reading; everything else is released for the slave.
    function automatic logic bit_sda(input logic wr, input logic rd, input logic nack,
                                     input logic [7:0] tx, input logic [3:0] idx);
        logic [2:0] sel;
        sel = 3'd7 - idx[2:0];
        if (idx < 4'd8) return wr & ~tx[sel];
        return rd & ~nack;
    endfunction

    // Byte-lane merge for PRESCALE writes; a zero quarter would never advance sensibly.
    always_comb begin
        prescale_wr = prescale_q;
        for (int i = 0; i < int'(PRESCALE_W); i++) begin
            if (wstrb[i / 8]) prescale_wr[i] = wdata[i];
        end
        if (prescale_wr == '0) prescale_wr = PRESCALE_W'(1);
    end

    always_comb begin
        rdata_mux = '0;
        case (raddr[3:2])
            2'd1:    rdata_mux = {24'd0, rxdata_q};
            2'd2:    rdata_mux = {29'd0, cmd_err_q, rx_nack_q, busy_q};
            2'd3:    rdata_mux = 32'(prescale_q);
            default: rdata_mux = '0;
        endcase
    end

`ifdef I2C_CLK_STRETCH_EN
    // While SCL is released but still sensed low, a slave is stretching: freeze the quarter.
    assign stall = (state_q != StIdle) && (qtr_q == 2'd1) && !scl_i;
`else
    assign stall = 1'b0;
`endif
    assign qend = (state_q != StIdle) && !stall && (cnt_q == prescale_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            prescale_q  <= PRESCALE_W'(DEFAULT_PRESCALE);
            cnt_q       <= '0;
            qtr_q       <= '0;
            bit_q       <= '0;
            txdata_q    <= '0;
            rxdata_q    <= '0;
            busy_q      <= 1'b0;
            rx_nack_q   <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_stop_q  <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_read_q  <= 1'b0;
            cmd_nack_q  <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            wready_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            wready_q <= wen;
            rvalid_q <= ren;
            if (ren) rdata_q <= rdata_mux;

            if (wen) begin
                case (waddr[3:2])
                    2'd0: if (wstrb[0]) begin
                        if (busy_q || (wdata[2] && wdata[3])) begin
                            cmd_err_q <= 1'b1;
                        end else if (|wdata[3:0]) begin
                            busy_q      <= 1'b1;
                            cnt_q       <= '0;
                            qtr_q       <= '0;
                            bit_q       <= '0;
                            cmd_stop_q  <= wdata[1];
                            cmd_write_q <= wdata[2];
                            cmd_read_q  <= wdata[3];
                            cmd_nack_q  <= wdata[4];
                            // Apply the first phase's q0 line action right away.
                            if (wdata[0]) begin
                                state_q  <= StStart;
                                sda_oe_q <= 1'b0;
                            end else if (wdata[2] || wdata[3]) begin
                                state_q  <= StBit;
                                sda_oe_q <= bit_sda(wdata[2], wdata[3], wdata[4], txdata_q, 4'd0);
                            end else begin
                                state_q  <= StStop;
                                sda_oe_q <= 1'b1;
                            end
                        end
                    end
                    2'd1: if (wstrb[0]) txdata_q <= wdata[7:0];
                    2'd2: if (wstrb[0] && wdata[2]) cmd_err_q <= 1'b0;
                    default: if (!busy_q) prescale_q <= prescale_wr;
                endcase
            end

            // Line actions for quarter k are issued at the end of quarter k-1.
            if (state_q != StIdle) begin
                if (stall) begin
                    cnt_q <= '0;
                end else if (!qend) begin
                    cnt_q <= cnt_q + PRESCALE_W'(1);
                end else begin
                    cnt_q <= '0;
                    qtr_q <= qtr_q + 2'd1;
                    case (state_q)
                        StStart: case (qtr_q)
                            2'd0: scl_oe_q <= 1'b0;
                            2'd1: sda_oe_q <= 1'b1;
                            2'd2: scl_oe_q <= 1'b1;
                            default: begin
                                if (cmd_write_q || cmd_read_q) begin
                                    state_q  <= StBit;
                                    sda_oe_q <= bit_sda(cmd_write_q, cmd_read_q, cmd_nack_q,
                                                        txdata_q, 4'd0);
                                end else if (cmd_stop_q) begin
                                    state_q  <= StStop;
                                    sda_oe_q <= 1'b1;
                                end else begin
                                    state_q <= StIdle;
                                    busy_q  <= 1'b0;
                                end
                            end
                        endcase
                        StBit: case (qtr_q)
                            2'd0: scl_oe_q <= 1'b0;
                            2'd2: begin
                                // Last cycle of q2: SDA has been stable with SCL high.
                                if (cmd_read_q && bit_q < 4'd8) rxdata_q <= {rxdata_q[6:0], sda_i};
                                if (cmd_write_q && bit_q == 4'd8) rx_nack_q <= sda_i;
                                scl_oe_q <= 1'b1;
                            end
                            2'd3: begin
                                if (bit_q != 4'd8) begin
                                    bit_q    <= bit_q + 4'd1;
                                    sda_oe_q <= bit_sda(cmd_write_q, cmd_read_q, cmd_nack_q,
                                                        txdata_q, bit_q + 4'd1);
                                end else if (cmd_stop_q) begin
                                    state_q  <= StStop;
                                    sda_oe_q <= 1'b1;
                                end else begin
                                    state_q <= StIdle;
                                    busy_q  <= 1'b0;
                                end
                            end
                            default: begin end
                        endcase
                        StStop: case (qtr_q)
                            2'd0: scl_oe_q <= 1'b0;
                            2'd1: sda_oe_q <= 1'b0;
                            2'd3: begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                            end
                            default: begin end
                        endcase
                        default: state_q <= StIdle;
                    endcase
                end
            end
        end
    end

    assign wready = wready_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign scl_oe = scl_oe_q;
    assign sda_oe = sda_oe_q;

    // Address bits outside [3:2] and unused data lanes are don't-care.
    assign unused_inputs = ^{waddr[31:4], waddr[1:0], raddr[31:4], raddr[1:0], wdata, wstrb, scl_i};

endmodule
